cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter D_FIRST, default 1: when set, D-cache wins the first simultaneous request after reset; when clear, I-cache wins it.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_pmem_read  input  1  I-cache line-read request; level, held until i_pmem_resp.
REQ-005 SHALL have port i_pmem_address  input  16 (lc3b_word)  I-cache line address.
REQ-006 SHALL have port i_pmem_rdata  output  128 (lc3b_line)  line returned to I-cache.
REQ-007 SHALL have port i_pmem_resp  output  1  I-cache transaction complete.
REQ-008 SHALL have port d_pmem_read  input  1  D-cache line-read request; level, held until d_pmem_resp.
REQ-009 SHALL have port d_pmem_write  input  1  D-cache line-writeback request; level, held until d_pmem_resp.
REQ-010 SHALL have port d_pmem_address  input  16 (lc3b_word)  D-cache line address.
REQ-011 SHALL have port d_pmem_wdata  input  128 (lc3b_line)  writeback line.
REQ-012 SHALL have port d_pmem_rdata  output  128 (lc3b_line)  line returned to D-cache.
REQ-013 SHALL have port d_pmem_resp  output  1  D-cache transaction complete.
REQ-014 SHALL have ports pmem_read, pmem_write  output  1 each  memory-side operation strobes.
REQ-015 SHALL have ports pmem_address  output  16, pmem_wdata  output  128  memory-side address/data.
REQ-016 SHALL have ports pmem_rdata  input  128, pmem_resp  input  1  memory-side return path.

Function
REQ-017 SHALL implement FSM with states IDLE, I_BUSY, D_BUSY.
REQ-018 IDLE: only I requesting -> I_BUSY; only D (read or write) requesting -> D_BUSY; both -> grant per round-robin flag; none -> stay IDLE.
REQ-019 Round-robin flag SHALL initialise per D_FIRST, and SHALL point to the other requester after each conflict-resolved grant; uncontested grants SHALL NOT change it.
REQ-020 On grant SHALL latch requester address, wdata and op (read/write) into registers; pmem_* outputs SHALL drive only from these registers.
REQ-021 pmem_read or pmem_write SHALL be high in every cycle of I_BUSY/D_BUSY and low in IDLE; both never high together.
REQ-022 Latency: request sampled in IDLE at edge t -> pmem strobe high from cycle t+1.
REQ-023 In a BUSY state with pmem_resp=1, SHALL assert the granted requester's resp combinationally that cycle with rdata = pmem_rdata, and SHALL enter IDLE on the next edge.
REQ-024 The non-granted requester's resp SHALL stay 0; its rdata SHALL be don't-care but SHALL NOT be X-producing (drive pmem_rdata to both).
REQ-025 Requester inputs changing during BUSY SHALL NOT affect pmem_address/pmem_wdata/op.
REQ-026 pmem_resp in IDLE SHALL be ignored (no requester resp).
REQ-027 d_pmem_read and d_pmem_write both high SHALL be treated as write.
REQ-028 Back-to-back: a request still high in IDLE (cycle after resp) SHALL be granted normally; minimum one IDLE cycle between transactions.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, clear latched address/wdata/op to 0, reload round-robin flag per D_FIRST, regardless of current state.
REQ-030 During and after reset all strobes and resps SHALL be 0; a pmem_resp for an aborted transaction SHALL be ignored.

Structure
REQ-031 lc3b_line and lc3b_word SHALL come from the shared lc3b_types package; FSM state enum SHALL be local to the module.
REQ-032 No sub-module; single module with one registered FSM, one flag, and latch registers.

Verification
REQ-033 I read, addr 0x1230, memory responds after 3 cycles with line 0xA5..A5 -> pmem_read high cycles 1-4, i_pmem_resp high cycle 4 with that data, d_pmem_resp 0.
REQ-034 D write addr 0x4560, wdata 0x0123..EF -> pmem_write high, pmem_address 0x4560, pmem_wdata matches; d_pmem_resp on pmem_resp.
REQ-035 I and D request same cycle, D_FIRST=1 -> D served first, then I after one IDLE cycle; repeat conflict -> I served first.
REQ-036 Change d_pmem_address 0x4560 -> 0x7770 mid-transaction -> pmem_address stays 0x4560.
REQ-037 rst asserted in D_BUSY, then pmem_resp pulsed -> strobes 0 next cycle, no resp to either cache, flag restored.
REQ-038 d_pmem_read and d_pmem_write both high -> pmem_write=1, pmem_read=0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types used by the cache and memory-side blocks.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache line reads and D-cache line reads/writebacks onto one
// physical-memory port. Transactions are latched at grant and held until pmem_resp.
//
// Handshake: a cache raises its read/write level and holds it until its resp
// pulses for one cycle; the memory side sees a strobe held high for the whole
// transaction and completes it by pulsing pmem_resp.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter bit D_FIRST = 1'b1
) (
    input  logic     clk,
    input  logic     rst,

    input  logic     i_pmem_read,
    input  lc3b_word i_pmem_address,
    output lc3b_line i_pmem_rdata,
    output logic     i_pmem_resp,

    input  logic     d_pmem_read,
    input  logic     d_pmem_write,
    input  lc3b_word d_pmem_address,
    input  lc3b_line d_pmem_wdata,
    output lc3b_line d_pmem_rdata,
    output logic     d_pmem_resp,

    output logic     pmem_read,
    output logic     pmem_write,
    output lc3b_word pmem_address,
    output lc3b_line pmem_wdata,
    input  lc3b_line pmem_rdata,
    input  logic     pmem_resp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t   state, state_next;
    logic     rr_d, rr_d_next;      // 1: D-cache wins the next conflict
    lc3b_word addr_q, addr_next;
    lc3b_line wdata_q, wdata_next;
    logic     wr_q, wr_next;

    logic i_req, d_req, grant_i, grant_d;

    assign i_req   = i_pmem_read;
    assign d_req   = d_pmem_read | d_pmem_write;
    assign grant_d = d_req & (~i_req | rr_d);
    assign grant_i = i_req & ~grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_d    <= D_FIRST;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state   <= state_next;
            rr_d    <= rr_d_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
            wr_q    <= wr_next;
        end
    end

    always_comb begin
        state_next = state;
        rr_d_next  = rr_d;
        addr_next  = addr_q;
        wdata_next = wdata_q;
        wr_next    = wr_q;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = D_BUSY;
                    addr_next  = d_pmem_address;
                    wdata_next = d_pmem_wdata;
                    // read+write together is a writeback
                    wr_next    = d_pmem_write;
                    if (i_req) rr_d_next = 1'b0;
                end else if (grant_i) begin
                    state_next = I_BUSY;
                    addr_next  = i_pmem_address;
                    wdata_next = '0;
                    wr_next    = 1'b0;
                    if (d_req) rr_d_next = 1'b1;
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pmem_read    = (state != IDLE) & ~wr_q;
    assign pmem_write   = (state != IDLE) &  wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_pmem_resp  = (state == I_BUSY) & pmem_resp;
    assign d_pmem_resp  = (state == D_BUSY) & pmem_resp;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: transaction-level model, per-cycle compare,
// expected grant-order queue and literal checks on the headline scenarios.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read, d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // expected grant order: {is_write, address}
    logic [16:0] exp_q[$];

    // model: owner 0 = none, 1 = I-cache, 2 = D-cache
    int           m_owner, prev_owner;
    logic         m_dnext;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    logic         m_wr;

    // memory responder and requester bookkeeping
    logic         mem_auto;
    int           mem_lat, mem_cnt;
    logic [127:0] mem_data;
    logic         i_drop, d_drop;
    int           txn_len, last_len;
    logic [127:0] last_i_data;
    logic         saw_i_resp, saw_d_resp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update();
        bit ireq, dreq;
        int pick;
        ireq = i_pmem_read;
        dreq = d_pmem_read | d_pmem_write;
        if (rst) begin
            m_owner = 0; m_addr = '0; m_wdata = '0; m_wr = 1'b0; m_dnext = 1'b1;
        end else if (m_owner == 0) begin
            pick = 0;
            if (ireq && dreq) begin
                pick    = m_dnext ? 2 : 1;
                m_dnext = (pick == 1);
            end else if (ireq) pick = 1;
            else if (dreq) pick = 2;
            if (pick == 1) begin
                m_addr = i_pmem_address; m_wr = 1'b0;
            end else if (pick == 2) begin
                m_addr = d_pmem_address; m_wdata = d_pmem_wdata; m_wr = d_pmem_write;
            end
            m_owner = pick;
        end else if (pmem_resp) begin
            m_owner = 0;
        end
    endtask

    task automatic compare();
        chk("pmem_read", pmem_read, (m_owner != 0) && !m_wr);
        chk("pmem_write", pmem_write, (m_owner != 0) && m_wr);
        chk("i_resp", i_pmem_resp, (m_owner == 1) && pmem_resp);
        chk("d_resp", d_pmem_resp, (m_owner == 2) && pmem_resp);
        if (m_owner != 0) chk("pmem_address", pmem_address, m_addr);
        if (m_owner == 2 && m_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
        if (i_pmem_resp) chk("i_rdata", i_pmem_rdata, pmem_rdata);
        if (d_pmem_resp) chk("d_rdata", d_pmem_rdata, pmem_rdata);
        if (m_owner != 0 && prev_owner == 0) begin
            if (exp_q.size() == 0) chk("unexpected_grant", {pmem_write, pmem_address}, 17'h0);
            else chk("grant_order", {pmem_write, pmem_address}, exp_q.pop_front());
            txn_len = 1;
        end else if (m_owner != 0) begin
            txn_len++;
        end
        if (m_owner != 0 && pmem_resp) last_len = txn_len;
        prev_owner = m_owner;
    endtask

    // one clock: model sees pre-edge inputs, stimulus moves #1 later, compare on negedge
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        if (i_drop) begin i_pmem_read = 1'b0; i_drop = 1'b0; end
        if (d_drop) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_drop = 1'b0; end
        if (mem_auto) begin
            if (pmem_read || pmem_write) begin
                mem_cnt++;
                pmem_resp  = (mem_cnt == mem_lat);
                pmem_rdata = mem_data;
            end else begin
                mem_cnt   = 0;
                pmem_resp = 1'b0;
            end
        end
        @(negedge clk);
        compare();
        if (i_pmem_resp) begin i_drop = 1'b1; last_i_data = i_pmem_rdata; saw_i_resp = 1'b1; end
        if (d_pmem_resp) begin d_drop = 1'b1; saw_d_resp = 1'b1; end
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            done = !i_pmem_read && !d_pmem_read && !d_pmem_write && (m_owner == 0);
        end
        if (!done) chk({name, "_timeout"}, 1'b0, 1'b1);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic conflict(input bit d_wins, input string name);
        if (d_wins) begin
            exp_q.push_back({1'b0, 16'h2000});
            exp_q.push_back({1'b0, 16'h3000});
        end else begin
            exp_q.push_back({1'b0, 16'h3000});
            exp_q.push_back({1'b0, 16'h2000});
        end
        mem_lat = 2;
        mem_data = {8{16'hBEEF}};
        i_pmem_address = 16'h3000; i_pmem_read = 1'b1;
        d_pmem_address = 16'h2000; d_pmem_read = 1'b1;
        wait_idle(name);
    endtask

    initial begin
        rst = 1'b1;
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;
        mem_auto = 1; mem_lat = 4; mem_cnt = 0; mem_data = '0;
        i_drop = 0; d_drop = 0; txn_len = 0; last_len = 0; last_i_data = '0;
        saw_i_resp = 0; saw_d_resp = 0;
        m_owner = 0; prev_owner = 0; m_dnext = 1; m_addr = '0; m_wdata = '0; m_wr = 0;

        step(); step();
        chk("reset_strobes", {pmem_read, pmem_write}, 2'b00);
        chk("reset_resps", {i_pmem_resp, d_pmem_resp}, 2'b00);
        chk("reset_address", pmem_address, 16'h0000);
        rst = 1'b0;
        step();

        // I read, memory answers in the fourth strobe cycle
        exp_q.push_back({1'b0, 16'h1230});
        mem_lat = 4; mem_data = {16{8'hA5}};
        i_pmem_address = 16'h1230; i_pmem_read = 1'b1;
        wait_idle("i_read");
        chk("i_read_len", last_len, 4);
        chk("i_read_data", last_i_data, {16{8'hA5}});
        chk("i_read_no_dresp", saw_d_resp, 1'b0);

        // D writeback with address/data changing mid-transaction
        saw_i_resp = 0; saw_d_resp = 0;
        exp_q.push_back({1'b1, 16'h4560});
        mem_lat = 5; mem_data = '0;
        d_pmem_address = 16'h4560;
        d_pmem_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
        d_pmem_write = 1'b1;
        step(); step();
        d_pmem_address = 16'h7770;
        d_pmem_wdata = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
        step();
        chk("d_write_addr_held", pmem_address, 16'h4560);
        chk("d_write_wdata", pmem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
        chk("d_write_strobe", {pmem_read, pmem_write}, 2'b01);
        wait_idle("d_write");
        chk("d_write_dresp", saw_d_resp, 1'b1);
        chk("d_write_no_iresp", saw_i_resp, 1'b0);

        // simultaneous requests alternate D, I, D
        conflict(1'b1, "conflict1");
        conflict(1'b0, "conflict2");
        conflict(1'b1, "conflict3");

        // read and write together is a writeback
        exp_q.push_back({1'b1, 16'h5000});
        mem_lat = 3;
        d_pmem_address = 16'h5000; d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        step();
        chk("rw_both_strobe", {pmem_read, pmem_write}, 2'b01);
        wait_idle("rw_both");

        // reset during D_BUSY, then a stray pmem_resp
        saw_i_resp = 0; saw_d_resp = 0;
        exp_q.push_back({1'b1, 16'h6000});
        mem_lat = 10;
        d_pmem_address = 16'h6000; d_pmem_write = 1'b1;
        step(); step();
        mem_auto = 1'b0; pmem_resp = 1'b0;
        rst = 1'b1; d_pmem_write = 1'b0;
        step();
        chk("abort_strobes", {pmem_read, pmem_write}, 2'b00);
        rst = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = {16{8'h5A}};
        step();
        chk("abort_stray_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        pmem_resp = 1'b0; mem_auto = 1'b1; mem_cnt = 0;
        step();
        chk("abort_no_resp_seen", {saw_i_resp, saw_d_resp}, 2'b00);
        // flag was pointing at I; reset must restore D priority
        conflict(1'b1, "conflict_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
